status_ctrl_unit: RTL

STATUS_CTRL_UNIT -- requirements
Module: status_ctrl_unit

---
 rtl/status_pkg.sv | 57 +++++
 rtl/status_stack.sv | 53 +++++
 rtl/status_ctrl_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/status_pkg.sv
// Shared definitions for the status/condition-code control unit:
// flag bit positions within a 4-bit status word {Z,C,N,V}, the machine- and
// micro-status-register operation encodings, and the select codes used by the
// condition-test, carry-in and shift-fill multiplexers.
package status_pkg;

  // Flag positions inside a status word ordered {Z,C,N,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    MS_HOLD     = 3'd0,
    MS_LOAD_ALU = 3'd1,
    MS_LOAD_EXT = 3'd2,
    MS_LOAD_USR = 3'd3,
    MS_SWAP     = 3'd4,
    MS_PUSH     = 3'd5,
    MS_POP      = 3'd6,
    MS_CLEAR    = 3'd7
  } ms_op_e;

  typedef enum logic [1:0] {
    US_HOLD     = 2'd0,
    US_LOAD_ALU = 2'd1,
    US_SET      = 2'd2,
    US_CLEAR    = 2'd3
  } us_op_e;

  // Condition-test select codes.
  localparam logic [2:0] CC_Z    = 3'd0;
  localparam logic [2:0] CC_C    = 3'd1;
  localparam logic [2:0] CC_N    = 3'd2;
  localparam logic [2:0] CC_V    = 3'd3;
  localparam logic [2:0] CC_LT   = 3'd4;  // N^V
  localparam logic [2:0] CC_LE   = 3'd5;  // (N^V)|Z
  localparam logic [2:0] CC_LS   = 3'd6;  // ~C|Z
  localparam logic [2:0] CC_TRUE = 3'd7;

  // Carry-in select codes.
  localparam logic [1:0] CIN_ZERO  = 2'd0;
  localparam logic [1:0] CIN_ONE   = 2'd1;
  localparam logic [1:0] CIN_C     = 2'd2;
  localparam logic [1:0] CIN_NOT_C = 2'd3;

  // Shift-fill select codes.
  localparam logic [2:0] SH_ZERO  = 3'd0;
  localparam logic [2:0] SH_ONE   = 3'd1;
  localparam logic [2:0] SH_C     = 3'd2;
  localparam logic [2:0] SH_ROT   = 3'd3;
  localparam logic [2:0] SH_ARITH = 3'd4;
  localparam logic [2:0] SH_NXV   = 3'd5;
  localparam logic [2:0] SH_USR_C = 3'd6;
  localparam logic [2:0] SH_ZERO2 = 3'd7;

endpackage

// File: rtl/status_stack.sv
// LIFO for saved machine-status words.
// Ports: clk, reset (sync, active high); push_i/pop_i request strobes;
// data_i word to push; top_o word at the stack top; cnt_o entry count;
// full_o/empty_o decoded from the count. A push when full or a pop when empty
// is ignored here; error reporting belongs to the caller.
module status_stack #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [3:0]    data_i,
  output logic [3:0]    top_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int IW = $clog2(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, rd_idx;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr_idx  = IW'(cnt_q);
  assign rd_idx  = IW'(cnt_q - CW'(1));
  assign top_o   = mem_q[rd_idx];
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !empty_o) cnt_d = cnt_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // NOTE: storage has no reset; the count alone defines which entries are
  // valid, and leaving the array unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (!reset && push_i && !full_o) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/status_ctrl_unit.sv
// Status and condition-code control: holds the machine status register (MSR)
// and micro status register (uSR), a save stack for MSR, and derives the
// condition-test, carry-in and shift-fill bits.
// Inputs: clk, reset (sync, active high); alu_flags/ext_flags {Z,C,N,V};
// ms_op/us_op register operations; flag_en per-flag MSR load enable;
// cc_src/cc_sel/cc_inv condition select; cin_sel; sh_sel/sh_dir/sh_en/
// sh_msb/sh_lsb shifter context; clr_err clears the sticky stack error.
// Outputs: ms_q/us_q register contents; ct condition result; cin carry-in;
// fill shift fill bit; stk_full/stk_empty/stk_err/stk_cnt stack status.
module status_ctrl_unit
  import status_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    alu_flags,
  input  logic [3:0]    ext_flags,
  input  logic [2:0]    ms_op,
  input  logic [1:0]    us_op,
  input  logic [3:0]    flag_en,
  input  logic          cc_src,
  input  logic [2:0]    cc_sel,
  input  logic          cc_inv,
  input  logic [1:0]    cin_sel,
  input  logic [2:0]    sh_sel,
  input  logic          sh_dir,
  input  logic          sh_en,
  input  logic          sh_msb,
  input  logic          sh_lsb,
  input  logic          clr_err,
  output logic [3:0]    ms_q,
  output logic [3:0]    us_q,
  output logic          ct,
  output logic          cin,
  output logic          fill,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err,
  output logic [CW-1:0] stk_cnt
);

  logic [3:0] ms_d, us_d, alu_src, stk_top;
  logic       err_q, err_d;
  logic       push_req, pop_req, cond, shifted_out;
  logic [3:0] r_src;
  ms_op_e     ms_op_e_w;
  us_op_e     us_op_e_w;

  assign ms_op_e_w = ms_op_e'(ms_op);
  assign us_op_e_w = us_op_e'(us_op);

  // Reset must not let a concurrent PUSH write a stack entry.
  assign push_req = (ms_op_e_w == MS_PUSH) && !reset;
  assign pop_req  = (ms_op_e_w == MS_POP)  && !reset;

  status_stack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .data_i  (ms_q),
    .top_o   (stk_top),
    .cnt_o   (stk_cnt),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // During a shift the carry flag captures the bit that fell off the end.
  assign shifted_out = sh_dir ? sh_msb : sh_lsb;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_src = alu_flags;
    if (sh_en) alu_src[FLAG_C] = shifted_out;

    us_d = us_q;
    unique case (us_op_e_w)
      US_HOLD:     us_d = us_q;
      US_LOAD_ALU: us_d = alu_flags;
      US_SET:      us_d = 4'b1111;
      US_CLEAR:    us_d = 4'b0000;
    endcase

    ms_d = ms_q;
    unique case (ms_op_e_w)
      MS_HOLD:     ms_d = ms_q;
      MS_LOAD_ALU: ms_d = (ms_q & ~flag_en) | (alu_src   & flag_en);
      MS_LOAD_EXT: ms_d = (ms_q & ~flag_en) | (ext_flags & flag_en);
      MS_LOAD_USR: ms_d = us_q;
      MS_SWAP: begin
        ms_d = us_q;
        us_d = ms_q;
      end
      MS_PUSH:     ms_d = ms_q;
      MS_POP:      ms_d = stk_empty ? ms_q : stk_top;
      MS_CLEAR:    ms_d = 4'b0000;
    endcase

    // Sticky error: a new fault in the same cycle as clr_err still wins.
    err_d = (err_q && !clr_err)
          || (ms_op_e_w == MS_PUSH && stk_full)
          || (ms_op_e_w == MS_POP  && stk_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_q  <= '0;
      us_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ms_q  <= ms_d;
      us_q  <= us_d;
      err_q <= err_d;
    end
  end

  assign stk_err = err_q;

  // Condition test on the selected registered status word.
  assign r_src = cc_src ? ms_q : us_q;

  always_comb begin
    cond = 1'b1;
    unique case (cc_sel)
      CC_Z:    cond = r_src[FLAG_Z];
      CC_C:    cond = r_src[FLAG_C];
      CC_N:    cond = r_src[FLAG_N];
      CC_V:    cond = r_src[FLAG_V];
      CC_LT:   cond = r_src[FLAG_N] ^ r_src[FLAG_V];
      CC_LE:   cond = (r_src[FLAG_N] ^ r_src[FLAG_V]) | r_src[FLAG_Z];
      CC_LS:   cond = ~r_src[FLAG_C] | r_src[FLAG_Z];
      CC_TRUE: cond = 1'b1;
    endcase
  end

  assign ct = cond ^ cc_inv;

  always_comb begin
    cin = 1'b0;
    unique case (cin_sel)
      CIN_ZERO:  cin = 1'b0;
      CIN_ONE:   cin = 1'b1;
      CIN_C:     cin = ms_q[FLAG_C];
      CIN_NOT_C: cin = ~ms_q[FLAG_C];
    endcase
  end

  always_comb begin
    fill = 1'b0;
    unique case (sh_sel)
      SH_ZERO:  fill = 1'b0;
      SH_ONE:   fill = 1'b1;
      SH_C:     fill = ms_q[FLAG_C];
      SH_ROT:   fill = sh_dir ? sh_msb : sh_lsb;
      SH_ARITH: fill = sh_dir ? 1'b0 : sh_msb;
      SH_NXV:   fill = ms_q[FLAG_N] ^ ms_q[FLAG_V];
      SH_USR_C: fill = us_q[FLAG_C];
      SH_ZERO2: fill = 1'b0;
    endcase
  end

endmodule
